// File: rtl/lab5_apb_pkg.sv
// lab5_apb_pkg: shared FSM state type, default bus widths and Lab5 register map
//   no ports; imported by lab5_apb_wdog and lab5_apb_master
package lab5_apb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam logic [31:0] ADDR_INA  = 32'h00;
   localparam logic [31:0] ADDR_INB  = 32'h04;
   localparam logic [31:0] ADDR_OUTC = 32'h08;
endpackage

// File: rtl/lab5_apb_wdog.sv
// lab5_apb_wdog: ACCESS-phase wait counter that flags an APB transfer timeout
//   iClk, iRsn : clock, asynchronous active-low reset
//   clear      : zero the counter (asserted in the cycle before ACCESS)
//   enable     : transfer is in ACCESS this cycle
//   iPready    : APB ready
//   timeout    : this ACCESS cycle is the TIMEOUT-th without ready (0 when TIMEOUT is 0)
module lab5_apb_wdog
   import lab5_apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic iClk,
   input  logic iRsn,
   input  logic clear,
   input  logic enable,
   input  logic iPready,
   output logic timeout
);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge iClk or negedge iRsn)
      if (!iRsn) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !iPready) cnt <= cnt + 1'b1;
   // cnt holds the wait cycles already seen, so this cycle brings the count to TIMEOUT;
   // a ready in the same cycle wins because the flag requires !iPready
   assign timeout = (TIMEOUT != 0) && enable && !iPready && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/lab5_apb_master.sv
// lab5_apb_master: single-outstanding command-to-APB bridge with wait-state timeout
//   iClk, iRsn                          : clock, asynchronous active-low reset
//   iCmdValid/oCmdReady                 : command handshake (ready only in IDLE)
//   iCmdWrite, iCmdAddr, iCmdWdata      : command contents
//   oRspValid, oRspRdata, oRspErr       : one-cycle response pulse
//   oPsel, oPenable, oPwrite, oPaddr, oPwdata, iPrdata, iPready, iPslverr : APB bus
module lab5_apb_master
   import lab5_apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              iClk,
   input  logic              iRsn,
   input  logic              iCmdValid,
   output logic              oCmdReady,
   input  logic              iCmdWrite,
   input  logic [ADDR_W-1:0] iCmdAddr,
   input  logic [DATA_W-1:0] iCmdWdata,
   output logic              oRspValid,
   output logic [DATA_W-1:0] oRspRdata,
   output logic              oRspErr,
   output logic              oPsel,
   output logic              oPenable,
   output logic              oPwrite,
   output logic [ADDR_W-1:0] oPaddr,
   output logic [DATA_W-1:0] oPwdata,
   input  logic [DATA_W-1:0] iPrdata,
   input  logic              iPready,
   input  logic              iPslverr
);
   apb_state_e state;
   logic live, accept, in_setup, in_access, done, abort;
   assign in_setup  = state == ST_SETUP;
   assign in_access = state == ST_ACCESS;
   // live keeps oCmdReady low through reset and raises it on the first edge after release
   assign oCmdReady = live && state == ST_IDLE;
   assign accept    = iCmdValid && oCmdReady;
   assign done      = in_access && iPready;
   assign oPsel     = state != ST_IDLE;
   assign oPenable  = in_access;
   lab5_apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .iClk    (iClk),
      .iRsn    (iRsn),
      .clear   (in_setup),
      .enable  (in_access),
      .iPready (iPready),
      .timeout (abort)
   );
   always_ff @(posedge iClk or negedge iRsn)
      if (!iRsn) begin
         state     <= ST_IDLE;
         live      <= 1'b0;
         oPwrite   <= 1'b0;
         oPaddr    <= '0;
         oPwdata   <= '0;
         oRspValid <= 1'b0;
         oRspErr   <= 1'b0;
         oRspRdata <= '0;
      end else begin
         live  <= 1'b1;
         state <= accept ? ST_SETUP : in_setup ? ST_ACCESS : (done || abort) ? ST_IDLE : state;
         if (accept) begin
            oPwrite <= iCmdWrite;
            oPaddr  <= iCmdAddr;
            oPwdata <= iCmdWdata;
         end
         oRspValid <= done || abort;
         oRspErr   <= done ? iPslverr : abort;
         oRspRdata <= (done && !oPwrite) ? iPrdata : '0;
      end
endmodule

// File: tb/tb_lab5_apb_master.sv
// tb_lab5_apb_master: Lab5 slave model, cycle model of the master and directed scenarios
module tb_lab5_apb_master;
   import lab5_apb_pkg::*;
   localparam int TO_LIM [2] = '{16, 4};
   logic iClk = 1'b0;
   logic iRsn = 1'b1;
   logic cmd_valid [2], cmd_ready [2], cmd_write [2];
   logic [31:0] cmd_addr [2], cmd_wdata [2];
   logic rsp_valid [2], rsp_err [2];
   logic [31:0] rsp_rdata [2];
   logic psel [2], penable [2], pwrite [2], pready [2], pslverr [2];
   logic [31:0] paddr [2], pwdata [2], prdata [2];
   logic [31:0] s_ina [2] = '{default: 0};
   logic [31:0] s_inb [2] = '{default: 0};
   logic [7:0] acc_cnt [2] = '{default: 0};
   logic [7:0] wait_n [2];
   logic err_en [2];
   logic m_live [2] = '{default: 0};
   logic m_act [2] = '{default: 0};
   logic m_write [2] = '{default: 0};
   logic m_rsp [2] = '{default: 0};
   logic m_err [2] = '{default: 0};
   logic [31:0] m_addr [2] = '{default: 0};
   logic [31:0] m_wdata [2] = '{default: 0};
   logic [31:0] m_rdata [2] = '{default: 0};
   int m_ph [2] = '{default: 0};
   logic nrsp;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 iClk = ~iClk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      lab5_apb_master #(.TIMEOUT(g == 0 ? 16 : 4)) dut (
         .iClk      (iClk),
         .iRsn      (iRsn),
         .iCmdValid (cmd_valid[g]),
         .oCmdReady (cmd_ready[g]),
         .iCmdWrite (cmd_write[g]),
         .iCmdAddr  (cmd_addr[g]),
         .iCmdWdata (cmd_wdata[g]),
         .oRspValid (rsp_valid[g]),
         .oRspRdata (rsp_rdata[g]),
         .oRspErr   (rsp_err[g]),
         .oPsel     (psel[g]),
         .oPenable  (penable[g]),
         .oPwrite   (pwrite[g]),
         .oPaddr    (paddr[g]),
         .oPwdata   (pwdata[g]),
         .iPrdata   (prdata[g]),
         .iPready   (pready[g]),
         .iPslverr  (pslverr[g])
      );
   end
   // Lab5 slave: INA/INB registers, OUTC = INA + INB, wait_n wait states, err_en refuses writes
   always_comb
      for (int g = 0; g < 2; g++) begin
         pready[g]  = penable[g] && acc_cnt[g] >= wait_n[g];
         pslverr[g] = pready[g] && err_en[g];
         prdata[g]  = paddr[g] == ADDR_OUTC ? s_ina[g] + s_inb[g] :
                      paddr[g] == ADDR_INA  ? s_ina[g] :
                      paddr[g] == ADDR_INB  ? s_inb[g] : 32'h0;
      end
   always @(posedge iClk)
      for (int g = 0; g < 2; g++) begin
         acc_cnt[g] <= penable[g] ? acc_cnt[g] + 8'd1 : 8'd0;
         if (pready[g] && pwrite[g] && !err_en[g]) begin
            if (paddr[g] == ADDR_INA) s_ina[g] <= pwdata[g];
            if (paddr[g] == ADDR_INB) s_inb[g] <= pwdata[g];
         end
      end
   task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, g, got, exp);
      end
   endtask
   // transaction model: phase = cycles since acceptance; ACCESS cycle index = phase - 1
   always @(negedge iClk)
      for (int g = 0; g < 2; g++) begin
         if (!iRsn) begin
            chk("rst_cmd_ready", g, cmd_ready[g], 0);
            chk("rst_psel", g, psel[g], 0);
            chk("rst_penable", g, penable[g], 0);
            chk("rst_pwrite", g, pwrite[g], 0);
            chk("rst_paddr", g, paddr[g], 0);
            chk("rst_pwdata", g, pwdata[g], 0);
            chk("rst_rsp_valid", g, rsp_valid[g], 0);
            chk("rst_rsp_err", g, rsp_err[g], 0);
            chk("rst_rsp_rdata", g, rsp_rdata[g], 0);
            m_live[g] = 0; m_act[g] = 0; m_rsp[g] = 0; m_write[g] = 0;
            m_addr[g] = 0; m_wdata[g] = 0;
         end else begin
            chk("cmd_ready", g, cmd_ready[g], m_live[g] && !m_act[g]);
            chk("psel", g, psel[g], m_act[g]);
            chk("penable", g, penable[g], m_act[g] && m_ph[g] >= 2);
            chk("pwrite", g, pwrite[g], m_write[g]);
            chk("paddr", g, paddr[g], m_addr[g]);
            chk("pwdata", g, pwdata[g], m_wdata[g]);
            chk("rsp_valid", g, rsp_valid[g], m_rsp[g]);
            if (m_rsp[g]) begin
               chk("rsp_err", g, rsp_err[g], m_err[g]);
               chk("rsp_rdata", g, rsp_rdata[g], m_rdata[g]);
            end
            nrsp = 0;
            if (m_act[g]) begin
               if (m_ph[g] >= 2 && pready[g]) begin
                  nrsp = 1; m_err[g] = pslverr[g]; m_rdata[g] = m_write[g] ? 32'h0 : prdata[g]; m_act[g] = 0;
               end else if (m_ph[g] >= 2 && TO_LIM[g] > 0 && m_ph[g] - 1 == TO_LIM[g]) begin
                  nrsp = 1; m_err[g] = 1; m_rdata[g] = 32'h0; m_act[g] = 0;
               end else m_ph[g]++;
            end else if (m_live[g] && cmd_valid[g]) begin
               m_act[g] = 1; m_ph[g] = 1;
               m_write[g] = cmd_write[g]; m_addr[g] = cmd_addr[g]; m_wdata[g] = cmd_wdata[g];
            end
            m_rsp[g] = nrsp;
            m_live[g] = 1;
         end
      end
   task automatic do_cmd(input int g, input logic w, input logic [31:0] a, input logic [31:0] d, input bit junk,
                         output logic [31:0] rd, output logic er, output int lat, output int psn, output bit stable);
      bit got;
      got = 0; lat = -1; psn = 0; stable = 1; rd = 0; er = 0;
      @(posedge iClk); #1;
      cmd_valid[g] = 1; cmd_write[g] = w; cmd_addr[g] = a; cmd_wdata[g] = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge iClk);
         got = cmd_ready[g];
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL accept[%0d]: got no oCmdReady in 20 cycles, expected acceptance", g);
         cmd_valid[g] = 0;
         return;
      end
      @(posedge iClk); #1;
      if (junk) begin
         cmd_write[g] = !w; cmd_addr[g] = ~a; cmd_wdata[g] = ~d;
      end else cmd_valid[g] = 0;
      for (int k = 1; k <= 60 && lat < 0; k++) begin
         @(negedge iClk);
         if (psel[g]) begin
            psn++;
            if (paddr[g] !== a || pwrite[g] !== w || pwdata[g] !== d) stable = 0;
         end
         if (rsp_valid[g]) begin
            lat = k; rd = rsp_rdata[g]; er = rsp_err[g];
            chk("ready_in_rsp", g, cmd_ready[g], 1);
         end else if (junk && k == 4) begin
            @(posedge iClk); #1;
            cmd_valid[g] = 0;
         end
      end
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_wait[%0d]: got no oRspValid in 60 cycles, expected a response", g);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL global_timeout: got no end of run by 100000 ns, expected completion");
      $fatal(1);
   end
   initial begin
      logic [31:0] rd;
      logic er;
      int lat, psn, rc;
      bit st, got;
      for (int g = 0; g < 2; g++) begin
         cmd_valid[g] = 0; cmd_write[g] = 0; cmd_addr[g] = 0; cmd_wdata[g] = 0;
         wait_n[g] = 0; err_en[g] = 0;
      end
      #2 iRsn = 0;
      #1 chk("lit_rst_ready", 0, cmd_ready[0], 0);
      chk("lit_rst_psel", 0, psel[0], 0);
      repeat (2) @(posedge iClk);
      #1 iRsn = 1;
      @(negedge iClk); chk("lit_ready_pre_edge", 0, cmd_ready[0], 0);
      @(negedge iClk); chk("lit_ready_post_edge", 0, cmd_ready[0], 1);
      do_cmd(0, 1, ADDR_INA, 32'h12345678, 0, rd, er, lat, psn, st);
      chk("lit_wr_ina_err", 0, er, 0);
      chk("lit_wr_ina_lat", 0, lat, 3);
      do_cmd(0, 1, ADDR_INB, 32'h00000001, 0, rd, er, lat, psn, st);
      chk("lit_wr_inb_rdata", 0, rd, 0);
      do_cmd(0, 0, ADDR_OUTC, 32'h0, 0, rd, er, lat, psn, st);
      chk("lit_outc_rdata", 0, rd, 32'h12345679);
      chk("lit_outc_err", 0, er, 0);
      chk("lit_outc_lat", 0, lat, 3);
      chk("lit_outc_psel_cycles", 0, psn, 2);
      wait_n[0] = 5;
      do_cmd(0, 0, ADDR_OUTC, 32'h0, 1, rd, er, lat, psn, st);
      chk("lit_wait5_rdata", 0, rd, 32'h12345679);
      chk("lit_wait5_lat", 0, lat, 8);
      chk("lit_wait5_psel_cycles", 0, psn, 7);
      chk("lit_wait5_stable", 0, st, 1);
      wait_n[0] = 0; err_en[0] = 1;
      do_cmd(0, 1, ADDR_INB, 32'h00000002, 0, rd, er, lat, psn, st);
      chk("lit_slverr_err", 0, er, 1);
      chk("lit_slverr_rdata", 0, rd, 0);
      err_en[0] = 0;
      do_cmd(0, 0, ADDR_OUTC, 32'h0, 0, rd, er, lat, psn, st);
      chk("lit_after_err_rdata", 0, rd, 32'h12345679);
      wait_n[1] = 8'hFF;
      do_cmd(1, 0, ADDR_INA, 32'h0, 0, rd, er, lat, psn, st);
      chk("lit_timeout_err", 1, er, 1);
      chk("lit_timeout_rdata", 1, rd, 0);
      chk("lit_timeout_lat", 1, lat, 6);
      chk("lit_timeout_psel_cycles", 1, psn, 5);
      wait_n[1] = 3;
      do_cmd(1, 1, ADDR_INA, 32'hCAFE0001, 0, rd, er, lat, psn, st);
      chk("lit_ready_at_limit_err", 1, er, 0);
      chk("lit_ready_at_limit_lat", 1, lat, 6);
      wait_n[1] = 0;
      do_cmd(1, 0, ADDR_INA, 32'h0, 0, rd, er, lat, psn, st);
      chk("lit_ready_at_limit_rdata", 1, rd, 32'hCAFE0001);
      wait_n[0] = 8'hFF;
      @(posedge iClk); #1;
      cmd_valid[0] = 1; cmd_write[0] = 0; cmd_addr[0] = ADDR_OUTC; cmd_wdata[0] = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge iClk);
         got = cmd_ready[0];
      end
      chk("lit_rst_case_accept", 0, got, 1);
      @(posedge iClk); #1 cmd_valid[0] = 0;
      @(posedge iClk);
      #1 chk("lit_in_access", 0, penable[0], 1);
      iRsn = 0;
      #1 chk("lit_async_psel", 0, psel[0], 0);
      chk("lit_async_penable", 0, penable[0], 0);
      chk("lit_async_paddr", 0, paddr[0], 0);
      chk("lit_async_ready", 0, cmd_ready[0], 0);
      chk("lit_async_rsp_valid", 0, rsp_valid[0], 0);
      rc = 0;
      repeat (2) @(posedge iClk);
      #1 iRsn = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge iClk);
         if (rsp_valid[0]) rc++;
      end
      chk("lit_no_rsp_after_rst", 0, rc, 0);
      wait_n[0] = 0;
      do_cmd(0, 0, ADDR_OUTC, 32'h0, 0, rd, er, lat, psn, st);
      chk("lit_post_rst_rdata", 0, rd, 32'h12345679);
      chk("lit_post_rst_lat", 0, lat, 3);
      repeat (2) @(negedge iClk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lab5_apb_master.md
LAB5_APB_MASTER -- requirements
Module: lab5_apb_master

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, provided by these ports:
- iClk  in  1  rising-edge clock
- iRsn  in  1  asynchronous active-low reset
REQ-005 The command port SHALL be:
- iCmdValid  in  1  command request
- oCmdReady  out  1  command accepted when high together with iCmdValid
- iCmdWrite  in  1  1 = write, 0 = read
- iCmdAddr  in  ADDR_W  target address
- iCmdWdata  in  DATA_W  write data
REQ-006 The response port SHALL be:
- oRspValid  out  1  one-cycle response pulse
- oRspRdata  out  DATA_W  read data
- oRspErr  out  1  PSLVERR or timeout
REQ-007 The APB port SHALL be:
- oPsel  out  1  select
- oPenable  out  1  enable
- oPwrite  out  1  write
- oPaddr  out  ADDR_W  address
- oPwdata  out  DATA_W  write data
- iPrdata  in  DATA_W  read data
- iPready  in  1  ready
- iPslverr  in  1  error

Function
REQ-008 The block SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-009 oCmdReady SHALL equal 1 only in IDLE; a command is accepted on a cycle where iCmdValid and oCmdReady are both high.
REQ-010 On acceptance, the block SHALL register iCmdWrite, iCmdAddr and iCmdWdata into oPwrite, oPaddr and oPwdata, and move to SETUP.
REQ-011 SETUP SHALL last exactly one cycle with oPsel=1 and oPenable=0, then move to ACCESS.
REQ-012 In ACCESS, oPsel=1 and oPenable=1; oPaddr, oPwrite and oPwdata SHALL remain stable until completion.
REQ-013 Completion SHALL be the first ACCESS cycle with iPready=1; on completion the FSM SHALL return to IDLE, with oPsel and oPenable low in the next cycle.
REQ-014 In the cycle after completion, oRspValid SHALL be 1 for exactly one cycle:
- oRspErr = iPslverr sampled at completion.
- oRspRdata = iPrdata for reads, 0 for writes.
REQ-015 Latency: accept in cycle N gives SETUP in N+1 and ACCESS from N+2; with zero wait states, oRspValid is in N+3.
REQ-016 Back-to-back operation: oCmdReady is high in the oRspValid cycle, so a new command can be accepted in that cycle.
REQ-017 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with iPready=0.
REQ-018 If TIMEOUT>0 and the counter reaches TIMEOUT, the block SHALL abort:
- Return to IDLE.
- Assert oRspValid with oRspErr=1 and oRspRdata=0 in the next cycle.
REQ-019 An iPready arriving in the same cycle the counter reaches TIMEOUT SHALL take priority: normal completion, no timeout.
REQ-020 iCmdValid outside IDLE SHALL be ignored; the command SHALL be neither queued nor corrupted.
REQ-021 oRspValid and oRspRdata are not held; the consumer SHALL take them in the pulse cycle.

Reset
REQ-022 While iRsn=0 (asynchronous), the block SHALL force:
- State = IDLE, wait counter = 0.
- oPsel, oPenable, oPwrite, oRspValid, oRspErr = 0.
- oPaddr, oPwdata, oRspRdata = 0.
- oCmdReady = 0.
REQ-023 oCmdReady SHALL rise on the first clock edge after iRsn deasserts.
REQ-024 Reset during SETUP or ACCESS SHALL abandon the transfer with no response pulse emitted.

Structure
REQ-025 A shared package lab5_apb_pkg SHALL hold:
- The FSM state enum.
- Default ADDR_W and DATA_W.
- Lab5 register map constants: ADDR_INA=0x00, ADDR_INB=0x04, ADDR_OUTC=0x08.
REQ-026 One sub-module, lab5_apb_wdog, SHALL hold the wait counter:
- Inputs: clear, enable, iPready.
- Output: timeout flag.
- Everything else stays in the top module.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Write 0x00←0x12345678, write 0x04←0x00000001, read 0x08 against the Lab5 APB slave and function block -> oRspRdata=0x12345679, oRspErr=0.
- Zero-wait read -> oRspValid exactly 3 cycles after acceptance; oPsel high for 2 cycles.
- iPready delayed 5 cycles -> address, data and write held stable; oRspValid 8 cycles after acceptance.
- TIMEOUT=4, iPready stuck low -> abort after 4 ACCESS cycles; oRspErr=1, oRspRdata=0.
- iPslverr=1 with iPready on a write -> oRspErr=1, oRspRdata=0.
- iRsn pulled low in ACCESS -> all outputs 0 immediately, no oRspValid, next command works normally.
